// File: rtl/game_tick_generator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_tick_generator_pkg
// Description : Shared game enums, default move periods and speed decoding.
// Revision    : 1.0 - initial release
// ============================================================================
package game_tick_generator_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT     = 2'd1,
        PAUSE    = 2'd2,
        END_GAME = 2'd3
    } game_state_e;

    typedef enum logic [1:0] {
        NORMAL_SPEED = 2'd0,
        FAST_SPEED   = 2'd1,
        SLOW_SPEED   = 2'd2
    } game_speed_e;

    typedef enum logic [1:0] {
        FSM_IDLE  = 2'd0,
        FSM_COUNT = 2'd1,
        FSM_HOLD  = 2'd2
    } tick_fsm_e;

    localparam int unsigned c_normal_period = 5_000_000;
    localparam int unsigned c_fast_period   = 2_500_000;
    localparam int unsigned c_slow_period   = 10_000_000;
    localparam int unsigned c_speedup_step  = 250_000;
    localparam int unsigned c_min_period    = 1_000_000;

    // The unused 2'b11 code falls back to normal speed.
    function automatic game_speed_e decode_speed(input logic [1:0] raw);
        case (raw)
            2'd1:    decode_speed = FAST_SPEED;
            2'd2:    decode_speed = SLOW_SPEED;
            default: decode_speed = NORMAL_SPEED;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_tick_generator_if.sv
`default_nettype none
// ============================================================================
// Module      : game_tick_generator_if
// Description : Game state/speed inputs and move-tick outputs of the tick block.
// Revision    : 1.0 - initial release
// ============================================================================
interface game_tick_generator_if;
    import game_tick_generator_pkg::*;

    game_state_e state;
    logic [1:0]  game_speed;
    logic        move_tick;
    logic [7:0]  tick_count;

    modport master (
        output state,
        output game_speed,
        input  move_tick,
        input  tick_count
    );

    modport slave (
        input  state,
        input  game_speed,
        output move_tick,
        output tick_count
    );

endinterface
`default_nettype wire

// File: rtl/game_tick_generator.sv
`default_nettype none
// ============================================================================
// Module      : game_tick_generator
// Description : Produces the one-cycle move_tick strobe from game speed/state.
//               Optional macro GAME_TICK_SPEEDUP_EN shortens the period as
//               tick_count grows.
// Revision    : 1.0 - initial release
// ============================================================================
module game_tick_generator
    import game_tick_generator_pkg::*;
#(
    parameter int unsigned NORMAL_PERIOD = c_normal_period,
    parameter int unsigned FAST_PERIOD   = c_fast_period,
    parameter int unsigned SLOW_PERIOD   = c_slow_period
`ifdef GAME_TICK_SPEEDUP_EN
    ,
    parameter int unsigned SPEEDUP_STEP  = c_speedup_step,
    parameter int unsigned MIN_PERIOD    = c_min_period
`endif
) (
    input  wire logic             system_clk,
    input  wire logic             rst,
    game_tick_generator_if.slave  tick_if
);

    localparam int unsigned W = $clog2(SLOW_PERIOD + 1);

    tick_fsm_e   fsm_state;
    game_speed_e active_speed_q, active_speed_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] base_period;
    logic [W-1:0] period;
    logic         move_tick_q, move_tick_d;
    logic [7:0]   tick_count_q, tick_count_d;
    logic         at_end;

    // The FSM tracks the game state with no lag so that RUN counts from its first cycle.
    always_comb begin
        case (tick_if.state)
            RUN:     fsm_state = FSM_COUNT;
            PAUSE:   fsm_state = FSM_HOLD;
            default: fsm_state = FSM_IDLE;
        endcase
    end

    always_comb begin
        case (active_speed_q)
            FAST_SPEED: base_period = W'(FAST_PERIOD);
            SLOW_SPEED: base_period = W'(SLOW_PERIOD);
            default:    base_period = W'(NORMAL_PERIOD);
        endcase
    end

`ifdef GAME_TICK_SPEEDUP_EN
    logic [W:0] speedup_dec;
    logic [W:0] speedup_diff;

    // tick_count only changes at a boundary or while idle, so the period is stable mid-interval.
    always_comb begin
        speedup_dec  = (W+1)'(tick_count_q >> 4) * (W+1)'(SPEEDUP_STEP);
        speedup_diff = {1'b0, base_period} - speedup_dec;
        if ((speedup_dec >= {1'b0, base_period}) || (speedup_diff < (W+1)'(MIN_PERIOD))) begin
            period = W'(MIN_PERIOD);
        end else begin
            period = speedup_diff[W-1:0];
        end
    end
`else
    assign period = base_period;
`endif

    assign at_end = (cnt_q >= (period - 1'b1));

    always_comb begin
        cnt_d          = cnt_q;
        active_speed_d = active_speed_q;
        tick_count_d   = tick_count_q;
        move_tick_d    = 1'b0;
        case (fsm_state)
            FSM_IDLE: begin
                cnt_d          = '0;
                active_speed_d = decode_speed(tick_if.game_speed);
                if (tick_if.state == WAIT) begin
                    tick_count_d = '0;
                end
            end
            FSM_COUNT: begin
                if (at_end) begin
                    cnt_d          = '0;
                    move_tick_d    = 1'b1;
                    active_speed_d = decode_speed(tick_if.game_speed);
                    if (tick_count_q != 8'hFF) begin
                        tick_count_d = tick_count_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // HOLD: everything frozen so RUN resumes the partial period.
            end
        endcase
    end

    always_ff @(posedge system_clk) begin
        if (rst) begin
            cnt_q          <= '0;
            active_speed_q <= NORMAL_SPEED;
            move_tick_q    <= 1'b0;
            tick_count_q   <= '0;
        end else begin
            cnt_q          <= cnt_d;
            active_speed_q <= active_speed_d;
            move_tick_q    <= move_tick_d;
            tick_count_q   <= tick_count_d;
        end
    end

    assign tick_if.move_tick  = move_tick_q;
    assign tick_if.tick_count = tick_count_q;

endmodule
`default_nettype wire

// File: tb/tb_game_tick_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_tick_generator
// Description : Scoreboard bench for game_tick_generator with short periods.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_tick_generator;
    import game_tick_generator_pkg::*;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   done = 1'b0;

    exp_t tick_q[$];
    exp_t lvl_q[$];

    game_tick_generator_if tick_if();

    game_tick_generator #(
        .NORMAL_PERIOD (4),
        .FAST_PERIOD   (2),
        .SLOW_PERIOD   (8)
`ifdef GAME_TICK_SPEEDUP_EN
        ,
        .SPEEDUP_STEP  (1),
        .MIN_PERIOD    (2)
`endif
    ) dut (
        .system_clk (clk),
        .rst        (rst),
        .tick_if    (tick_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tick(input int c, input int n);
        exp_t e;
        e.cyc = c;
        e.cnt = (n > 255) ? 255 : n;
        tick_q.push_back(e);
    endtask

    task automatic push_lvl(input int c, input int tc);
        exp_t e;
        e.cyc = c;
        e.cnt = tc;
        lvl_q.push_back(e);
    endtask

    // Monitor: compares every observed strobe and requested level check.
    always @(negedge clk) begin
        exp_t e;
        while (tick_q.size() > 0 && tick_q[0].cyc < cyc) begin
            e = tick_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missed_tick: expected tick at cycle %0d (count %0d), none by cycle %0d",
                     e.cyc, e.cnt, cyc);
        end
        while (lvl_q.size() > 0 && lvl_q[0].cyc <= cyc) begin
            e = lvl_q.pop_front();
            vectors++;
            if (e.cyc != cyc || tick_if.move_tick !== 1'b0 || tick_if.tick_count !== 8'(e.cnt)) begin
                miscompares++;
                $display("FAIL level_check cyc=%0d: move_tick=%b tick_count=%0d, required move_tick=0 tick_count=%0d at cycle %0d",
                         cyc, tick_if.move_tick, tick_if.tick_count, e.cnt, e.cyc);
            end
        end
        if (tick_if.move_tick !== 1'b0) begin
            vectors++;
            if (tick_q.size() == 0 || tick_q[0].cyc != cyc) begin
                miscompares++;
                $display("FAIL unexpected_tick: move_tick=%b at cycle %0d, next tick required at cycle %0d",
                         tick_if.move_tick, cyc, (tick_q.size() > 0) ? tick_q[0].cyc : -1);
            end else begin
                e = tick_q.pop_front();
                if (tick_if.tick_count !== 8'(e.cnt)) begin
                    miscompares++;
                    $display("FAIL tick_count at cycle %0d: got %0d, required %0d",
                             cyc, tick_if.tick_count, e.cnt);
                end
            end
        end
        if (done) begin
            vectors++;
            if (tick_q.size() != 0) begin
                miscompares++;
                $display("FAIL pending_ticks: %0d outstanding, required 0", tick_q.size());
            end
            vectors++;
            if (lvl_q.size() != 0) begin
                miscompares++;
                $display("FAIL pending_levels: %0d outstanding, required 0", lvl_q.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end else if (cyc > 5000) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: cycle %0d reached, required completion by 5000", cyc);
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

    initial begin
        int t;
        int tt;
        int per;
        rst                = 1'b1;
        tick_if.state      = RUN;
        tick_if.game_speed = 2'd0;

        // Reset held with RUN present: nothing may move, including the cycle after release.
        for (int c = 1; c <= 4; c++) push_lvl(c, 0);
        step(3);
        rst = 1'b0;
        t   = cyc;
        for (int k = 1; k <= 5; k++) push_tick(t + 4 * k, k);
        step(20);

        // Mid-period switch to FAST takes effect only at the next boundary.
        t = cyc;
        push_tick(t + 4, 6);
        push_tick(t + 6, 7);
        push_tick(t + 8, 8);
        push_tick(t + 10, 9);
        step(2);
        tick_if.game_speed = 2'd1;
        step(8);

        tick_if.state      = WAIT;
        tick_if.game_speed = 2'd0;
        step(2);
        push_lvl(cyc, 0);

        // Pause after two counts, resume finishes the partial period.
        tick_if.state = RUN;
        t = cyc;
        step(2);
        tick_if.state = PAUSE;
        step(10);
        tick_if.state = RUN;
        push_tick(t + 14, 1);
        step(2);

        // PAUSE in the terminal cycle: no tick, counter frozen at P-1.
        step(3);
        tick_if.state = PAUSE;
        step(3);
        push_lvl(cyc, 1);
        tick_if.state = RUN;
        push_tick(cyc + 1, 2);
        step(1);

        // END_GAME in the terminal cycle: no tick, counter cleared, count held.
        step(3);
        tick_if.state = END_GAME;
        step(2);
        push_lvl(cyc, 2);
        tick_if.state = RUN;
        t = cyc;
        push_tick(t + 4, 3);
        push_tick(t + 8, 4);
        push_tick(t + 12, 5);
        step(12);

        // WAIT after five ticks, then the 2'b11 code must run at the normal period.
        tick_if.state      = WAIT;
        tick_if.game_speed = 2'd3;
        step(2);
        push_lvl(cyc, 0);
        tick_if.state = RUN;
        t = cyc;
        push_tick(t + 4, 1);
        push_tick(t + 8, 2);
        step(8);

        tick_if.state      = WAIT;
        tick_if.game_speed = 2'd2;
        step(2);
        tick_if.state = RUN;
        t = cyc;
        push_tick(t + 8, 1);
        push_tick(t + 16, 2);
        step(16);

        tick_if.state      = WAIT;
        tick_if.game_speed = 2'd0;
        step(2);
`ifdef GAME_TICK_SPEEDUP_EN
        // Period drops by one every 16 ticks from 4, never below 2.
        tick_if.state = RUN;
        t  = cyc;
        tt = t;
        for (int n = 1; n <= 52; n++) begin
            per = 4 - ((n - 1) / 16);
            if (per < 2) per = 2;
            tt = tt + per;
            push_tick(tt, n);
        end
        step(tt - t);
`else
        // tick_count saturates at 255 while ticks keep coming.
        tick_if.game_speed = 2'd1;
        step(1);
        tick_if.state = RUN;
        t = cyc;
        for (int n = 1; n <= 260; n++) push_tick(t + 2 * n, n);
        step(520);
`endif
        tick_if.state = WAIT;
        step(2);
        done = 1'b1;
    end

endmodule
`default_nettype wire
